fetch_unit: RTL

- Instruction fetch stage. It is the producer of the 16-bit Instruction word that the decode stage consumes.
- Holds the PC and issues requests to instruction memory over a req/done handshake that may stall for several cycles.
- Registers the returned word with a valid flag, holding it under downstream stall.
- Handles redirects from branch/jump resolution, HALT detection and memory error.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/done accesses to instruction
// memory and presents one registered instruction word (with valid) to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OP  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] Instruction,
    output logic [15:0] PC_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] { FETCH, HALTING, HALTED, ERROR } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pending_pc;
    logic        drop;
    logic        in_flight;
    logic        out_free;
    logic        accept;
    logic        redirect_live;

    // A request must be held until done, so in_flight keeps it up even when
    // the output register is stalled; otherwise ask only when there is room.
    assign out_free      = !instr_valid || !stall;
    assign imem_req      = !rst && (state == FETCH) && (in_flight || out_free);
    assign imem_addr     = pc;
    assign accept        = imem_req && imem_done;
    assign redirect_live = redirect && (state == FETCH || state == HALTING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending_pc  <= RESET_PC;
            drop        <= 1'b0;
            in_flight   <= 1'b0;
            Instruction <= 16'h0800;
            PC_plus2    <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else if (redirect_live) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
            // An access that cannot finish this cycle must run to completion at
            // the old address; its data is thrown away and the target applied then.
            if (imem_req && !imem_done) begin
                pending_pc <= redirect_pc;
                drop       <= 1'b1;
                in_flight  <= 1'b1;
            end else begin
                pc         <= redirect_pc;
                drop       <= 1'b0;
                in_flight  <= 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        in_flight <= 1'b0;
                        if (drop) begin
                            pc   <= pending_pc;
                            drop <= 1'b0;
                            if (instr_valid && !stall)
                                instr_valid <= 1'b0;
                        end else if (imem_err) begin
                            state       <= ERROR;
                            err         <= 1'b1;
                            instr_valid <= 1'b0;
                        end else begin
                            Instruction <= imem_rdata;
                            PC_plus2    <= pc + 16'd2;
                            pc          <= pc + 16'd2;
                            instr_valid <= 1'b1;
                            if (imem_rdata[15:11] == HALT_OP)
                                state <= HALTING;
                        end
                    end else begin
                        if (imem_req)
                            in_flight <= 1'b1;
                        if (instr_valid && !stall)
                            instr_valid <= 1'b0;
                    end
                end
                HALTING: begin
                    if (instr_valid && !stall) begin
                        state       <= HALTED;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                HALTED, ERROR: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
